fifo_reader: RTL and testbench



---
 rtl/fifo_reader.sv | 133 +++++++++++++
 tb/tb_fifo_reader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_reader.sv
// ---------------------------------------------------------------------------
// fifo_reader
//   Drain-side companion to the dual-clock BRAM FIFO. Issues reads on the
//   FIFO read port and absorbs its one-cycle registered read latency. Each
//   WIDTH-bit word (WIDTH = OUTW*RATIO) is serialized into RATIO beats of
//   OUTW bits on a valid/ready stream.
//
//   Optional build macro: FIFO_READER_MSBFIRST_EN
//     undefined : beat k = wbuf[k*OUTW +: OUTW]           (LSB slice first)
//     defined   : beat k = wbuf[(RATIO-1-k)*OUTW +: OUTW] (MSB slice first)
//
// Ports
//   clk_i         read-side clock (same as the FIFO's clk_read_i)
//   rst_i         asynchronous reset, active low
//   fifo_read_o   read strobe to FIFO read_i
//   fifo_data_i   FIFO data_o, valid the cycle after a read strobe
//   fifo_empty_i  FIFO empty_o
//   data_o        current beat (0 while no word is held)
//   valid_o       data_o holds a valid beat
//   ready_i       consumer accepts the beat when valid_o && ready_i
//   busy_o        a read is in flight or a word is still held
// ---------------------------------------------------------------------------
module fifo_reader #(
  parameter int OUTW  = 8,
  parameter int RATIO = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  fifo_read_o,
  input  logic [OUTW*RATIO-1:0] fifo_data_i,
  input  logic                  fifo_empty_i,
  output logic [OUTW-1:0]       data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  busy_o
);

  localparam int WIDTH = OUTW * RATIO;
  localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

  // IDLE: nothing held; WAIT: read issued last cycle (pend);
  // SHIFT: word held in wbuf (full). pend and full are never both set.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_SHIFT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  wbuf_q, wbuf_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic              pend;
  logic              full;
  logic              fire;
  logic              lastfire;
  logic              rd;
  logic [OUTW-1:0]   beat;

  assign pend     = (state_q == S_WAIT);
  assign full     = (state_q == S_SHIFT);
  assign fire     = full && ready_i;
  assign lastfire = fire && (cnt_q == LAST);

  // Next word is fetched in the same cycle the last beat leaves, so a
  // continuously non-empty FIFO yields a single bubble cycle between words.
  // Gating on rst_i keeps the strobe low while reset is asserted.
  assign rd = rst_i && !fifo_empty_i && !pend && (!full || lastfire);

  always_comb begin
    state_d = state_q;
    wbuf_d  = wbuf_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (rd) state_d = S_WAIT;
      end
      S_WAIT: begin
        // FIFO output register now holds the word requested last cycle.
        wbuf_d  = fifo_data_i;
        cnt_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (lastfire) begin
          cnt_d   = '0;
          state_d = rd ? S_WAIT : S_IDLE;
        end else if (fire) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Beat selection: scan instead of a computed part-select so any RATIO
  // (power of two or not) maps cleanly.
  always_comb begin
    beat = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (cnt_q == CW'(k)) begin
`ifdef FIFO_READER_MSBFIRST_EN
        beat = wbuf_q[(RATIO-1-k)*OUTW +: OUTW];
`else
        beat = wbuf_q[k*OUTW +: OUTW];
`endif
      end
    end
  end

  // ---- register stage ----
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      wbuf_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wbuf_q  <= wbuf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fifo_read_o = rd;
  assign valid_o     = full;
  assign data_o      = full ? beat : '0;
  assign busy_o      = pend || full;

endmodule

// File: tb/tb_fifo_reader.sv
module tb_fifo_reader;

  localparam int OUTW  = 8;
  localparam int RATIO = 4;
  localparam logic [31:0] JUNK = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ready;
  logic        t_empty;
  logic [31:0] t_data;
  logic [31:0] mdata;
  logic        use_model;

  logic        fifo_read;
  logic        fifo_empty;
  logic [31:0] fifo_data;
  logic [7:0]  data;
  logic        valid;
  logic        busy;

  // Behavioural FIFO: flat array with write/read indices, registered read.
  logic [31:0] fmem [1024];
  int          wp = 0;
  int          rp = 0;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q [$];

  assign fifo_empty = use_model ? (wp == rp) : t_empty;
  assign fifo_data  = use_model ? mdata : t_data;

  always #5 clk = ~clk;

  fifo_reader #(.OUTW(OUTW), .RATIO(RATIO)) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .fifo_read_o (fifo_read),
    .fifo_data_i (fifo_data),
    .fifo_empty_i(fifo_empty),
    .data_o      (data),
    .valid_o     (valid),
    .ready_i     (ready),
    .busy_o      (busy)
  );

  always @(posedge clk) begin
    if (use_model && fifo_read && (wp != rp)) begin
      mdata <= fmem[rp];
      rp    <= rp + 1;
    end
  end

  // Beat k of a word, as the consumer should see it.
  function automatic logic [7:0] bt(input logic [31:0] w, input int k);
`ifdef FIFO_READER_MSBFIRST_EN
    return w[(RATIO-1-k)*OUTW +: OUTW];
`else
    return w[k*OUTW +: OUTW];
`endif
  endfunction

  typedef struct {
    logic        empty;
    logic [31:0] fdata;
    logic        rdy;
    logic        e_rd;
    logic        e_vld;
    logic [7:0]  e_dat;
    logic        e_bsy;
  } vec_t;

  vec_t tbl [$];

  function automatic void add(input logic e, input logic [31:0] fd, input logic r,
                              input logic xrd, input logic xv, input logic [7:0] xd,
                              input logic xb);
    vec_t v;
    v.empty = e; v.fdata = fd; v.rdy = r;
    v.e_rd = xrd; v.e_vld = xv; v.e_dat = xd; v.e_bsy = xb;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic xrd, input logic xv,
                     input logic [7:0] xd, input logic xb);
    checks++;
    if ({fifo_read, valid, data, busy} !== {xrd, xv, xd, xb}) begin
      errors++;
      $display("FAIL %s: got rd=%b vld=%b data=%h busy=%b, want rd=%b vld=%b data=%h busy=%b",
               nm, fifo_read, valid, data, busy, xrd, xv, xd, xb);
    end
  endtask

  task automatic drive(input logic e, input logic [31:0] fd, input logic r);
    @(posedge clk); #1;
    t_empty = e; t_data = fd; ready = r;
  endtask

  // Per-cycle scoreboard state for the randomized phase.
  logic       p_read  = 1'b0;
  logic       p_stall = 1'b0;
  logic [7:0] p_data  = 8'h00;

  task automatic mon();
    logic [7:0] e;
    if (valid && ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat: got unexpected beat %h, want none", data);
      end else begin
        e = exp_q.pop_front();
        if (data !== e) begin
          errors++;
          $display("FAIL beat: got %h, want %h", data, e);
        end
      end
    end
    if (fifo_read) begin
      checks++;
      if (fifo_empty || p_read) begin
        errors++;
        $display("FAIL read_rule: got read with empty=%b prev_read=%b, want both 0",
                 fifo_empty, p_read);
      end
    end
    checks++;
    if (busy !== (valid || p_read)) begin
      errors++;
      $display("FAIL busy: got %b, want %b", busy, valid || p_read);
    end
    if (!valid) begin
      checks++;
      if (data !== 8'h00) begin
        errors++;
        $display("FAIL idle_data: got %h, want 00", data);
      end
    end
    if (p_stall) begin
      checks++;
      if (!valid || data !== p_data) begin
        errors++;
        $display("FAIL stall_hold: got vld=%b data=%h, want vld=1 data=%h", valid, data, p_data);
      end
    end
    p_read  = fifo_read;
    p_stall = valid && !ready;
    p_data  = data;
  endtask

  task automatic push_word(input logic [31:0] w);
    fmem[wp] = w;
    for (int k = 0; k < RATIO; k++) exp_q.push_back(bt(w, k));
    wp = wp + 1;
  endtask

  initial begin
    logic [31:0] w, w1, w2;
    int n;
    bit done;

    rst_n = 1'b0; t_empty = 1'b1; t_data = 32'h0; ready = 1'b0;
    use_model = 1'b0; mdata = 32'h0;

    // Directed table
    for (int i = 0; i < 10; i++) add(1, 32'h0, 0, 0, 0, 8'h00, 0);
    w = 32'hDDCCBBAA;
    add(0, JUNK, 1, 1, 0, 8'h00, 0);
    add(1, w,    1, 0, 0, 8'h00, 1);
    for (int k = 0; k < RATIO; k++) add(1, JUNK, 1, 0, 1, bt(w, k), 1);
    add(1, JUNK, 1, 0, 0, 8'h00, 0);
    w1 = 32'h04030201; w2 = 32'h08070605;
    add(0, JUNK, 1, 1, 0, 8'h00, 0);
    add(0, w1,   1, 0, 0, 8'h00, 1);
    for (int k = 0; k < RATIO-1; k++) add(0, JUNK, 1, 0, 1, bt(w1, k), 1);
    add(0, JUNK, 1, 1, 1, bt(w1, RATIO-1), 1);
    add(1, w2,   1, 0, 0, 8'h00, 1);
    for (int k = 0; k < RATIO; k++) add(1, JUNK, 1, 0, 1, bt(w2, k), 1);
    add(1, JUNK, 1, 0, 0, 8'h00, 0);
    add(0, JUNK, 1, 1, 0, 8'h00, 0);
    add(1, w,    1, 0, 0, 8'h00, 1);
    add(1, JUNK, 1, 0, 1, bt(w, 0), 1);
    add(1, JUNK, 1, 0, 1, bt(w, 1), 1);
    for (int i = 0; i < 5; i++) add(0, JUNK, 0, 0, 1, bt(w, 2), 1);
    add(1, JUNK, 1, 0, 1, bt(w, 2), 1);
    add(1, JUNK, 1, 0, 1, bt(w, 3), 1);
    add(1, JUNK, 1, 0, 0, 8'h00, 0);

    #1 chk("reset", 0, 0, 8'h00, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].empty, tbl[i].fdata, tbl[i].rdy);
      @(negedge clk);
      chk($sformatf("row%0d", i), tbl[i].e_rd, tbl[i].e_vld, tbl[i].e_dat, tbl[i].e_bsy);
    end

    // Reset in the middle of a word
    w2 = 32'h44332211;
    drive(0, JUNK, 1); @(negedge clk); chk("rm_read",  1, 0, 8'h00, 0);
    drive(1, w,    1); @(negedge clk); chk("rm_wait",  0, 0, 8'h00, 1);
    drive(1, JUNK, 1); @(negedge clk); chk("rm_b0",    0, 1, bt(w, 0), 1);
    drive(1, JUNK, 1); @(negedge clk); chk("rm_b1",    0, 1, bt(w, 1), 1);
    drive(0, JUNK, 1);
    #2 rst_n = 1'b0;
    #1 chk("rm_async", 0, 0, 8'h00, 0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("rm_reread", 1, 0, 8'h00, 0);
    drive(1, w2, 1); @(negedge clk); chk("rm_wait2", 0, 0, 8'h00, 1);
    for (int k = 0; k < RATIO; k++) begin
      drive(1, JUNK, 1); @(negedge clk);
      chk($sformatf("rm_w2b%0d", k), 0, 1, bt(w2, k), 1);
    end
    drive(1, JUNK, 1); @(negedge clk); chk("rm_idle", 0, 0, 8'h00, 0);

    // Randomized phase against the behavioural FIFO + beat-stream model
    use_model = 1'b1;
    n = 0;
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0 && wp < 1000) begin
        push_word($urandom);
        n++;
      end
      @(negedge clk);
      mon();
    end
    done = 1'b0;
    for (int c = 0; c < 4000 && !done; c++) begin
      @(posedge clk); #1;
      ready = 1'b1;
      @(negedge clk);
      mon();
      if (exp_q.size() == 0 && !busy) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain: got %0d beats outstanding busy=%b, want 0 and idle", exp_q.size(), busy);
    end
    checks++;
    if (rp != wp) begin
      errors++;
      $display("FAIL fifo_drained: got rp=%0d, want %0d", rp, wp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
